// File: rtl/ntt_pkg.sv
// Shared NTT definitions: default transform size, datapath modulus and the
// stage-controller state encoding.
package ntt_pkg;

   localparam int unsigned NTT_N     = 256;
   localparam int unsigned NTT_LOG_N = $clog2(NTT_N);
   localparam int unsigned NTT_Q     = 8380417;
   localparam int unsigned NTT_Q_W   = $clog2(NTT_Q);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } ntt_ctrl_state_t;

   // Modulus at datapath width, for butterfly units that reduce mod Q.
   function automatic logic [NTT_Q_W-1:0] ntt_q();
      return NTT_Q_W'(NTT_Q);
   endfunction

   // Address width needed for the default transform length.
   function automatic int unsigned ntt_addr_w();
      return NTT_LOG_N;
   endfunction

endpackage

// File: rtl/ntt_wr_delay.sv
// Fixed-depth shift register carrying the write-back strobe and addresses
// alongside the butterfly pipeline.
module ntt_wr_delay #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 17
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            sr[i] <= '0;
         end
      end else begin
         sr[0] <= d;
         for (int i = 1; i < int'(DEPTH); i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// In-place Cooley-Tukey NTT sequencer: one butterfly per cycle, with a drain
// gap between stages so every stage sees the previous stage's write-backs.
module ntt_stage_ctrl
   import ntt_pkg::*;
#(
   parameter  int unsigned N        = NTT_N,
   parameter  int unsigned PIPE_LAT = 2,
   localparam int unsigned LOG_N    = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [LOG_N-1:0] stage,
   output logic             rd_en,
   output logic [LOG_N-1:0] rd_addr_a,
   output logic [LOG_N-1:0] rd_addr_b,
   output logic [LOG_N-1:0] tw_addr,
   output logic             wr_en,
   output logic [LOG_N-1:0] wr_addr_a,
   output logic [LOG_N-1:0] wr_addr_b
);

   localparam int unsigned BW   = LOG_N - 1;
   localparam int unsigned HALF = N / 2;
   localparam int unsigned CW   = $clog2(PIPE_LAT + 1);
   localparam int unsigned DW   = 1 + 2 * LOG_N;

   ntt_ctrl_state_t  state;
   logic [BW-1:0]    bfly;
   logic [LOG_N-1:0] k;
   logic [CW-1:0]    drain_cnt;

   logic [BW-1:0]    bfly_nxt;
   logic [LOG_N-1:0] stage_nxt;
   logic [LOG_N-1:0] k_inc;
   logic [LOG_N-1:0] len_cur;
   logic [LOG_N-1:0] len_nxt_stage;
   logic [LOG_N-1:0] nxt_addr_a;
   logic             grp_start;
   logic             last_bfly;
   logic             last_drain;
   logic             last_stage;
   logic [DW-1:0]    wr_bus;

   // Half-span of a butterfly in stage s: N >> (s+1), as a shift.
   function automatic logic [LOG_N-1:0] half_len(input logic [LOG_N-1:0] s);
      return LOG_N'(1) << (LOG_N'(LOG_N - 1) - s);
   endfunction

   // Butterfly index -> upper address: group bits move up one place, offset stays.
   function automatic logic [LOG_N-1:0] addr_a(input logic [BW-1:0] b,
                                               input logic [LOG_N-1:0] s);
      logic [LOG_N-1:0] bx;
      logic [LOG_N-1:0] lm;
      bx = LOG_N'(b);
      lm = half_len(s) - LOG_N'(1);
      return ((bx & ~lm) << 1) | (bx & lm);
   endfunction

   always_comb begin
      bfly_nxt      = bfly + BW'(1);
      stage_nxt     = stage + LOG_N'(1);
      k_inc         = k + LOG_N'(1);
      len_cur       = half_len(stage);
      len_nxt_stage = half_len(stage_nxt);
      nxt_addr_a    = addr_a(bfly_nxt, stage);
      grp_start     = (LOG_N'(bfly_nxt) & (len_cur - LOG_N'(1))) == '0;
      last_bfly     = bfly == BW'(HALF - 1);
      last_drain    = drain_cnt == CW'(PIPE_LAT - 1);
      last_stage    = stage == LOG_N'(LOG_N - 1);
   end

   // Controller FSM with registered issue outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bfly      <= '0;
         k         <= LOG_N'(1);
         drain_cnt <= '0;
         stage     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state     <= ST_RUN;
                  busy      <= 1'b1;
                  rd_en     <= 1'b1;
                  stage     <= '0;
                  bfly      <= '0;
                  k         <= LOG_N'(1);
                  rd_addr_a <= '0;
                  rd_addr_b <= half_len('0);
                  tw_addr   <= LOG_N'(1);
               end
            end
            ST_RUN: begin
               if (last_bfly) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= '0;
                  rd_en     <= 1'b0;
                  rd_addr_a <= '0;
                  rd_addr_b <= '0;
                  tw_addr   <= '0;
               end else begin
                  bfly      <= bfly_nxt;
                  rd_addr_a <= nxt_addr_a;
                  rd_addr_b <= nxt_addr_a | len_cur;
                  if (grp_start) begin
                     k       <= k_inc;
                     tw_addr <= k_inc;
                  end else begin
                     tw_addr <= k;
                  end
               end
            end
            ST_DRAIN: begin
               if (!last_drain) begin
                  drain_cnt <= drain_cnt + CW'(1);
               end else if (last_stage) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  // Next stage opens with a new group, so k advances here too.
                  state     <= ST_RUN;
                  stage     <= stage_nxt;
                  bfly      <= '0;
                  k         <= k_inc;
                  rd_en     <= 1'b1;
                  rd_addr_a <= '0;
                  rd_addr_b <= len_nxt_stage;
                  tw_addr   <= k_inc;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               stage <= '0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   ntt_wr_delay #(
      .DEPTH (PIPE_LAT),
      .W     (DW)
   ) u_wr_delay (
      .clk (clk),
      .clr (rst),
      .d   ({rd_en, rd_addr_a, rd_addr_b}),
      .q   (wr_bus)
   );

   assign {wr_en, wr_addr_a, wr_addr_b} = wr_bus;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: three configurations checked cycle by cycle against
// a loop-nest model of the stage/group/butterfly walk.
module tb_ntt_stage_ctrl;
   import ntt_pkg::*;

   localparam int MAXC = 1100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start8, start256, start4;

   logic       busy8, done8, rd_en8, wr_en8;
   logic [2:0] stage8, ra8, rb8, tw8, wa8, wb8;
   logic       busy256, done256, rd_en256, wr_en256;
   logic [7:0] stage256, ra256, rb256, tw256, wa256, wb256;
   logic       busy4, done4, rd_en4, wr_en4;
   logic [1:0] stage4, ra4, rb4, tw4, wa4, wb4;

   ntt_stage_ctrl #(.N(8), .PIPE_LAT(2)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
      .stage(stage8), .rd_en(rd_en8), .rd_addr_a(ra8), .rd_addr_b(rb8),
      .tw_addr(tw8), .wr_en(wr_en8), .wr_addr_a(wa8), .wr_addr_b(wb8));

   ntt_stage_ctrl #(.N(256), .PIPE_LAT(2)) u_dut256 (
      .clk(clk), .rst(rst), .start(start256), .busy(busy256), .done(done256),
      .stage(stage256), .rd_en(rd_en256), .rd_addr_a(ra256), .rd_addr_b(rb256),
      .tw_addr(tw256), .wr_en(wr_en256), .wr_addr_a(wa256), .wr_addr_b(wb256));

   ntt_stage_ctrl #(.N(4), .PIPE_LAT(1)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .busy(busy4), .done(done4),
      .stage(stage4), .rd_en(rd_en4), .rd_addr_a(ra4), .rd_addr_b(rb4),
      .tw_addr(tw4), .wr_en(wr_en4), .wr_addr_a(wa4), .wr_addr_b(wb4));

   typedef struct packed {
      logic       busy, done, rd_en, wr_en;
      logic [7:0] stage, a, b, tw, wa, wb;
   } obs_t;

   int n_assert = 0;
   int n_fail   = 0;

   int e_rd [MAXC];
   int e_a  [MAXC];
   int e_b  [MAXC];
   int e_tw [MAXC];
   int e_st [MAXC];
   int e_bsy[MAXC];
   int e_dn [MAXC];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int log2i(input int n);
      int l = 0;
      while ((1 << l) < n) l++;
      return l;
   endfunction

   function automatic obs_t sample(input int sel);
      obs_t o;
      case (sel)
         0: o = '{busy8, done8, rd_en8, wr_en8, 8'(stage8), 8'(ra8), 8'(rb8), 8'(tw8), 8'(wa8), 8'(wb8)};
         1: o = '{busy256, done256, rd_en256, wr_en256, stage256, ra256, rb256, tw256, wa256, wb256};
         default: o = '{busy4, done4, rd_en4, wr_en4, 8'(stage4), 8'(ra4), 8'(rb4), 8'(tw4), 8'(wa4), 8'(wb4)};
      endcase
      return o;
   endfunction

   function automatic logic [31:0] state_of(input int sel);
      case (sel)
         0: return 32'(u_dut8.state);
         1: return 32'(u_dut256.state);
         default: return 32'(u_dut4.state);
      endcase
   endfunction

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0: start8 = v;
         1: start256 = v;
         default: start4 = v;
      endcase
   endtask

   task automatic check_zero(input int sel);
      obs_t o;
      o = sample(sel);
      check("z_busy",  32'(o.busy),  0);
      check("z_done",  32'(o.done),  0);
      check("z_rd_en", 32'(o.rd_en), 0);
      check("z_wr_en", 32'(o.wr_en), 0);
      check("z_stage", 32'(o.stage), 0);
      check("z_rd_a",  32'(o.a),  0);
      check("z_rd_b",  32'(o.b),  0);
      check("z_tw",    32'(o.tw), 0);
      check("z_wr_a",  32'(o.wa), 0);
      check("z_wr_b",  32'(o.wb), 0);
   endtask

   // Expected issue timeline: walk stages, groups and butterflies directly.
   task automatic build_model(input int n, input int pl, output int tdone);
      int t, k, len, lg;
      for (int i = 0; i < MAXC; i++) begin
         e_rd[i] = 0; e_a[i] = 0; e_b[i] = 0; e_tw[i] = 0;
         e_st[i] = 0; e_bsy[i] = 0; e_dn[i] = 0;
      end
      lg = log2i(n);
      t  = 1;
      k  = 1;
      for (int s = 0; s < lg; s++) begin
         len = n >> (s + 1);
         for (int g = 0; g < n / (2 * len); g++) begin
            for (int j = g * 2 * len; j < g * 2 * len + len; j++) begin
               e_rd[t] = 1; e_a[t] = j; e_b[t] = j + len; e_tw[t] = k;
               e_st[t] = s; e_bsy[t] = 1;
               t++;
            end
            k++;
         end
         for (int d = 0; d < pl; d++) begin
            e_bsy[t] = 1; e_st[t] = s;
            t++;
         end
      end
      e_dn[t] = 1;
      tdone   = t;
   endtask

   task automatic run(input int sel, input int n, input int pl,
                      input int ign_at, input bit ign_done, input int rst_at);
      int   lg, tdone, tend, nrd, nwr, last_tw, done_seen, xw;
      bit   aborted, pulse;
      obs_t o;
      lg = log2i(n);
      build_model(n, pl, tdone);
      tend      = (rst_at > 0) ? rst_at + 6 : tdone + 5;
      nrd       = 0;
      nwr       = 0;
      last_tw   = -1;
      done_seen = -1;
      set_start(sel, 1'b1);
      for (int t = 1; t <= tend; t++) begin
         step();
         o       = sample(sel);
         aborted = (rst_at > 0) && (t > rst_at);
         if (aborted) begin
            check_zero(sel);
            if (t == rst_at + 1) begin
               check("rst_state", state_of(sel), 32'(ST_IDLE));
               rst = 1'b0;
            end
         end else begin
            check("busy",  32'(o.busy),  e_bsy[t]);
            check("done",  32'(o.done),  e_dn[t]);
            check("rd_en", 32'(o.rd_en), e_rd[t]);
            if (e_bsy[t] != 0) check("stage", 32'(o.stage), e_st[t]);
            if (e_rd[t] != 0) begin
               check("rd_a", 32'(o.a),  e_a[t]);
               check("rd_b", 32'(o.b),  e_b[t]);
               check("tw",   32'(o.tw), e_tw[t]);
            end
            xw = (t > pl) ? e_rd[t-pl] : 0;
            check("wr_en", 32'(o.wr_en), xw);
            if (xw != 0) begin
               check("wr_a", 32'(o.wa), e_a[t-pl]);
               check("wr_b", 32'(o.wb), e_b[t-pl]);
            end
         end
         if (o.rd_en) begin nrd++; last_tw = int'(o.tw); end
         if (o.wr_en) nwr++;
         if (o.done && done_seen < 0) done_seen = t;
         pulse = (t == ign_at) || (ign_done && t == tdone);
         if (rst_at > 0 && t >= rst_at) pulse = 1'b0;
         set_start(sel, pulse);
         if (rst_at > 0 && t == rst_at) rst = 1'b1;
      end
      set_start(sel, 1'b0);
      if (rst_at == 0) begin
         check("rd_count",   nrd, (n / 2) * lg);
         check("wr_count",   nwr, (n / 2) * lg);
         check("last_tw",    last_tw, n - 1);
         check("done_cycle", done_seen, 1 + lg * (n / 2 + pl));
      end
   endtask

   task automatic idle(input int sel, input int cycles);
      obs_t o;
      for (int i = 0; i < cycles; i++) begin
         step();
         o = sample(sel);
         check("idle_busy",  32'(o.busy),  0);
         check("idle_rd_en", 32'(o.rd_en), 0);
      end
   endtask

   initial begin
      int sel, n, pl, td, ra, ia;
      rst = 1'b1;
      start8 = 1'b0; start256 = 1'b0; start4 = 1'b0;
      repeat (3) step();
      for (int s = 0; s < 3; s++) check_zero(s);
      rst = 1'b0;
      step();
      for (int s = 0; s < 3; s++) check_zero(s);

      run(0, 8, 2, 3, 1'b1, 0);
      idle(0, 3);
      run(1, 256, 2, 50, 1'b1, 0);
      idle(1, 4);
      run(0, 8, 2, -1, 1'b0, 7);
      run(0, 8, 2, -1, 1'b0, 0);
      run(2, 4, 1, 2, 1'b1, 0);
      idle(2, 2);

      for (int i = 0; i < 8; i++) begin
         sel = int'($urandom_range(0, 2));
         case (sel)
            0: begin n = 8;   pl = 2; end
            1: begin n = 256; pl = 2; end
            default: begin n = 4; pl = 1; end
         endcase
         td = 1 + log2i(n) * (n / 2 + pl);
         ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, td - 1)) : 0;
         ia = int'($urandom_range(2, (ra > 0) ? ra - 1 : td - 1));
         idle(sel, int'($urandom_range(1, 4)));
         run(sel, n, pl, ia, ra == 0, ra);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
